calculator_param: RTL and testbench

- Parametrised successor to the fixed 4-digit calculator top.
- Generalises digit count; adds a 2-bit operation select (add/sub/mul), an overflow flag, and slider auto-repeat.
- Integrates button debounce, a three-phase entry FSM (operand A, operand B, result), arithmetic, and the multiplexed 7-segment display scan.
- Sits directly under the board top-level.

---
 rtl/calculator_pkg.sv | 47 ++++
 rtl/button_debounce.sv | 55 +++++
 rtl/calculator_param.sv | 264 ++++++++++++++++++++++++++
 tb/tb_calculator_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// ---------------------------------------------------------------------------
// calculator_pkg
// Shared types and helpers for the parametrised calculator.
//   state_t    : entry phases (operand A, operand B, result shown)
//   op_t       : arithmetic operation selected by the operation sliders
//   hex_to_seg : nibble -> active-low 7-segment glyph (bit6=g ... bit0=a)
// ---------------------------------------------------------------------------
package calculator_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser followed by a stability counter. The debounced level
// follows the synchronised input only after it has differed from the current
// level for DB_OVERFLOW+1 consecutive cycles. rise_pulse is a registered
// one-cycle pulse issued in the same cycle the level goes high.
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   in_undeb   in  raw button input
//   level      out debounced level
//   rise_pulse out one-cycle pulse on debounced rising edge
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DB_OVERFLOW = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic in_undeb,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DB_OVERFLOW > 0) ? $clog2(DB_OVERFLOW + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_OVERFLOW);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= in_undeb;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            // Any cycle agreeing with the current level restarts the count,
            // so a glitch shorter than DB_OVERFLOW+1 cycles never lands.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level      <= sync2;
                rise_pulse <= sync2;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calculator_param.sv
// ---------------------------------------------------------------------------
// calculator_param
// Hex calculator: sliders build an operand digit by digit, enter steps
// through operand A -> operand B -> result, clear returns to operand A.
// Result is A op B (add/sub/mul) truncated to W = 4*NUM_DIGITS bits with an
// overflow/borrow flag. The shown value is scanned over a multiplexed
// 7-segment display.
//   clk              in  system clock
//   reset            in  asynchronous active-low reset
//   button_clr_undeb in  raw clear button
//   button_ent_undeb in  raw enter button
//   sld              in  digit sliders, bit i increments hex digit i
//   sld_op           in  00 add, 01 sub, 10 mul, 11 add
//   digit_select     out active-low one-hot anode enable
//   led_select       out active-low segments, bit6=g ... bit0=a
//   overflow         out result overflow/borrow flag
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits
// above digit 0 (digit_select keeps scanning normally).
// ---------------------------------------------------------------------------
module calculator_param
    import calculator_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int DB_OVERFLOW      = 1000,
    parameter int SLIDER_OVERFLOW  = 25000000,
    parameter int REFRESH_OVERFLOW = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button_clr_undeb,
    input  logic                  button_ent_undeb,
    input  logic [NUM_DIGITS-1:0] sld,
    input  logic [1:0]            sld_op,
    output logic [NUM_DIGITS-1:0] digit_select,
    output logic [6:0]            led_select,
    output logic                  overflow
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RCW   = $clog2(SLIDER_OVERFLOW + 2);
    localparam int RFW   = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [RCW-1:0]   RPT_MAX  = RCW'(SLIDER_OVERFLOW + 1);
    localparam logic [RFW-1:0]   REF_MAX  = RFW'(REFRESH_OVERFLOW);

    // ---------------- buttons ----------------
    logic clr_level, clr_rise, ent_level, ent_rise;
    logic clr_act, ent_act;

    button_debounce #(.DB_OVERFLOW(DB_OVERFLOW)) u_db_clr (
        .clk        (clk),
        .reset      (reset),
        .in_undeb   (button_clr_undeb),
        .level      (clr_level),
        .rise_pulse (clr_rise)
    );

    button_debounce #(.DB_OVERFLOW(DB_OVERFLOW)) u_db_ent (
        .clk        (clk),
        .reset      (reset),
        .in_undeb   (button_ent_undeb),
        .level      (ent_level),
        .rise_pulse (ent_rise)
    );

    // The pulse is only ever raised together with the level; qualifying on
    // both keeps the action tied to a genuinely pressed button.
    assign clr_act = clr_rise & clr_level;
    assign ent_act = ent_rise & ent_level;

    // ---------------- slider / op synchronisers ----------------
    logic [NUM_DIGITS-1:0] sld_s1, sld_s2, sld_prev;
    logic [1:0]            op_s1, op_s2;
    logic [RCW-1:0]        rpt_cnt;
    logic                  any_held, rpt_fire;
    logic [NUM_DIGITS-1:0] inc_mask;

    assign any_held = |sld_s2;
    // The counter starts at 0 on the first held cycle, so the first repeat
    // lands SLIDER_OVERFLOW+1 cycles after the initial increment.
    assign rpt_fire = any_held && (rpt_cnt == RPT_MAX);
    assign inc_mask = (sld_s2 & ~sld_prev) | (rpt_fire ? sld_s2 : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sld_s1   <= '0;
            sld_s2   <= '0;
            sld_prev <= '0;
            op_s1    <= '0;
            op_s2    <= '0;
            rpt_cnt  <= '0;
        end else begin
            sld_s1   <= sld;
            sld_s2   <= sld_s1;
            sld_prev <= sld_s2;
            op_s1    <= sld_op;
            op_s2    <= op_s1;
            if (!any_held) begin
                rpt_cnt <= '0;
            end else if (rpt_fire) begin
                rpt_cnt <= RCW'(1);
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

    // ---------------- datapath ----------------
    state_t         state;
    logic [W-1:0]   entry, a_reg, result;
    logic [W-1:0]   entry_inc;
    op_t            op;
    logic [W:0]     sum_ext;
    logic [2*W-1:0] prod;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;

    // Per-digit increment, no carry between digits; frozen while showing
    // the result.
    always_comb begin
        entry_inc = entry;
        if (state != RESULT) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (inc_mask[i]) begin
                    entry_inc[i*4 +: 4] = entry[i*4 +: 4] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        case (op_s2)
            2'b01:   op = OP_SUB;
            2'b10:   op = OP_MUL;
            default: op = OP_ADD;
        endcase
    end

    assign sum_ext = {1'b0, a_reg} + {1'b0, entry_inc};
    assign prod    = {{W{1'b0}}, a_reg} * {{W{1'b0}}, entry_inc};

    always_comb begin
        alu_res = sum_ext[W-1:0];
        alu_ovf = sum_ext[W];
        case (op)
            OP_SUB: begin
                alu_res = a_reg - entry_inc;
                alu_ovf = (a_reg < entry_inc);
            end
            OP_MUL: begin
                alu_res = prod[W-1:0];
                alu_ovf = |prod[2*W-1:W];
            end
            default: begin
                alu_res = sum_ext[W-1:0];
                alu_ovf = sum_ext[W];
            end
        endcase
    end

    // ---------------- entry FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ENTER_A;
            entry    <= '0;
            a_reg    <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (clr_act) begin
            state    <= ENTER_A;
            entry    <= '0;
            a_reg    <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (ent_act) begin
                        a_reg <= entry_inc;
                        entry <= '0;
                        state <= ENTER_B;
                    end else begin
                        entry <= entry_inc;
                    end
                end
                ENTER_B: begin
                    entry <= entry_inc;
                    if (ent_act) begin
                        result   <= alu_res;
                        overflow <= alu_ovf;
                        state    <= RESULT;
                    end
                end
                RESULT: begin
                    if (ent_act) begin
                        entry    <= '0;
                        overflow <= 1'b0;
                        state    <= ENTER_A;
                    end
                end
                default: state <= ENTER_A;
            endcase
        end
    end

    // ---------------- display scan ----------------
    logic [RFW-1:0]   ref_cnt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     disp_val;
    logic [3:0]       nib;
    logic [6:0]       seg_next;

    assign disp_val = (state == RESULT) ? result : entry;

    always_comb begin
        nib = disp_val[3:0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib = disp_val[i*4 +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // blank[i]: digit i and every digit above it are zero. Digit 0 is never
    // blanked so a zero value still shows one glyph.
    logic [NUM_DIGITS-1:0] blank;
    logic                  higher_zero;

    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            higher_zero = higher_zero & (disp_val[i*4 +: 4] == 4'd0);
            blank[i]    = higher_zero;
        end
    end

    assign seg_next = blank[idx] ? SEG_BLANK : hex_to_seg(nib);
`else
    assign seg_next = hex_to_seg(nib);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt      <= '0;
            idx          <= '0;
            digit_select <= ~NUM_DIGITS'(1);
            led_select   <= 7'b1000000;
        end else begin
            if (ref_cnt == REF_MAX) begin
                ref_cnt <= '0;
                idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            digit_select <= ~(NUM_DIGITS'(1) << idx);
            led_select   <= seg_next;
        end
    end

endmodule

// File: tb/tb_calculator_param.sv
// ---------------------------------------------------------------------------
// tb_calculator_param
// Directed and randomised stimulus for calculator_param. A behavioural model
// tracks entry/A/result/overflow with plain arithmetic; the display is read
// back by following the scan and decoding each digit against a glyph table.
// ---------------------------------------------------------------------------
module tb_calculator_param;
    import calculator_pkg::*;

    localparam int ND = 4;
    localparam int SO = 3;

    logic          clk;
    logic          reset;
    logic          button_clr_undeb;
    logic          button_ent_undeb;
    logic [ND-1:0] sld;
    logic [1:0]    sld_op;
    logic [ND-1:0] digit_select;
    logic [6:0]    led_select;
    logic          overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model
    state_t      m_state;
    logic [15:0] m_entry, m_a, m_result;
    logic        m_ovf;
    logic [1:0]  m_op;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    calculator_param #(
        .NUM_DIGITS       (ND),
        .DB_OVERFLOW      (1),
        .SLIDER_OVERFLOW  (SO),
        .REFRESH_OVERFLOW (10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .button_clr_undeb (button_clr_undeb),
        .button_ent_undeb (button_ent_undeb),
        .sld              (sld),
        .sld_op           (sld_op),
        .digit_select     (digit_select),
        .led_select       (led_select),
        .overflow         (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input logic [15:0] v, input int i);
        logic [15:0] sh;
        sh = v >> (4 * i);
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && sh == 16'd0) return 7'b1111111;
`endif
        return seg_tab[sh[3:0]];
    endfunction

    function automatic logic [15:0] m_disp();
        return (m_state == RESULT) ? m_result : m_entry;
    endfunction

    // Follow the scan through every digit and decode its glyph.
    task automatic check_display(input string tag);
        logic [15:0] v;
        v = m_disp();
        for (int i = 0; i < ND; i++) begin
            int waited;
            logic [ND-1:0] want_sel;
            waited   = 0;
            want_sel = ~(ND'(1) << i);
            while (digit_select !== want_sel && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            check($sformatf("%s_sel%0d", tag, i), 32'(digit_select), 32'(want_sel));
            check($sformatf("%s_seg%0d", tag, i), 32'(led_select), 32'(exp_glyph(v, i)));
        end
    endtask

    // Hold slider i for n synchronised cycles: one increment on the first
    // cycle, then one every SO+1 cycles while held.
    task automatic hold_slider(input int i, input int n);
        int incs;
        logic [3:0] nib;
        sld[i] = 1'b1;
        tick(n);
        sld[i] = 1'b0;
        tick(4);
        if (m_state != RESULT && n > 0) begin
            incs = (n - 1) / (SO + 1) + 1;
            nib  = 4'((((m_entry >> (4 * i)) & 16'hF) + 16'(incs)) % 16);
            m_entry = (m_entry & ~(16'hF << (4 * i))) | (16'(nib) << (4 * i));
        end
    endtask

    task automatic set_value(input logic [15:0] v);
        for (int i = 0; i < ND; i++) begin
            int d;
            d = int'((v >> (4 * i)) & 16'hF);
            if (d > 0) hold_slider(i, (SO + 1) * (d - 1) + 1);
        end
    endtask

    function automatic void model_enter();
        logic [31:0] wide;
        case (m_state)
            ENTER_A: begin
                m_a     = m_entry;
                m_entry = 16'd0;
                m_state = ENTER_B;
            end
            ENTER_B: begin
                case (m_op)
                    2'b01: begin
                        wide  = 32'(m_a) - 32'(m_entry);
                        m_ovf = (m_a < m_entry);
                    end
                    2'b10: begin
                        wide  = 32'(m_a) * 32'(m_entry);
                        m_ovf = (wide > 32'hFFFF);
                    end
                    default: begin
                        wide  = 32'(m_a) + 32'(m_entry);
                        m_ovf = (wide > 32'hFFFF);
                    end
                endcase
                m_result = wide[15:0];
                m_state  = RESULT;
            end
            default: begin
                m_entry = 16'd0;
                m_ovf   = 1'b0;
                m_state = ENTER_A;
            end
        endcase
    endfunction

    function automatic void model_clear();
        m_state  = ENTER_A;
        m_entry  = 16'd0;
        m_a      = 16'd0;
        m_result = 16'd0;
        m_ovf    = 1'b0;
    endfunction

    task automatic press(input logic clr, input logic ent);
        button_clr_undeb = clr;
        button_ent_undeb = ent;
        tick(6);
        button_clr_undeb = 1'b0;
        button_ent_undeb = 1'b0;
        tick(8);
        if (clr) model_clear();
        else if (ent) model_enter();
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input string tag);
        sld_op = op;
        m_op   = op;
        set_value(a);
        press(1'b0, 1'b1);
        set_value(b);
        press(1'b0, 1'b1);
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check_display({tag, "_res"});
        press(1'b0, 1'b1);
        check({tag, "_ovf_clr"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_state"}, 32'(dut.state), 32'(m_state));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset            = 1'b0;
        button_clr_undeb = 1'b0;
        button_ent_undeb = 1'b0;
        sld              = '0;
        sld_op           = 2'b00;
        m_op             = 2'b00;
        model_clear();

        // reset state
        tick(3);
        check("rst_sel_in", 32'(digit_select), 32'h0000000E);
        check("rst_seg_in", 32'(led_select), 32'h00000040);
        reset = 1'b1;
        tick(1);
        check("rst_sel", 32'(digit_select), 32'h0000000E);
        check("rst_seg", 32'(led_select), 32'h00000040);
        check("rst_ovf", 32'(overflow), 32'h0);
        tick(20);
        check("idle_state", 32'(dut.state), 32'(ENTER_A));
        check_display("rst_disp");

        // slider increments and auto-repeat
        hold_slider(0, 9);
        check("sld0_val", 32'(m_entry), 32'h0003);
        check_display("sld0");
        hold_slider(1, 69);
        check_display("sld1_wrap");

        // add 0x12 + 0x34
        press(1'b1, 1'b0);
        run_op(16'h0012, 16'h0034, 2'b00, "add");
        // sub with borrow
        run_op(16'h0001, 16'h0002, 2'b01, "sub");
        // mul overflow
        run_op(16'h0100, 16'h0100, 2'b10, "mul");

        // randomised operations (op 11 behaves as add)
        for (int k = 0; k < 5; k++) begin
            logic [15:0] ra, rb;
            logic [1:0]  rop;
            ra  = 16'($urandom);
            rb  = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom);
            rop = 2'($urandom_range(0, 3));
            run_op(ra, rb, rop, $sformatf("rnd%0d", k));
        end

        // clear and enter together in ENTER_B: clear wins
        set_value(16'h0005);
        press(1'b0, 1'b1);
        set_value(16'h0007);
        check("pre_clr_state", 32'(dut.state), 32'(ENTER_B));
        press(1'b1, 1'b1);
        check("clr_state", 32'(dut.state), 32'(ENTER_A));
        check("clr_a", 32'(dut.a_reg), 32'(m_a));
        check_display("clr_disp");

        // one-cycle enter glitch is rejected
        set_value(16'h0023);
        button_ent_undeb = 1'b1;
        tick(1);
        button_ent_undeb = 1'b0;
        tick(12);
        check("glitch_state", 32'(dut.state), 32'(m_state));
        check_display("glitch_disp");

        // zero value display
        press(1'b1, 1'b0);
        check_display("zero_disp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
